// File: rtl/ctrl_sequencer_if.sv
// Control-strobe bundle between ctrl_sequencer (master) and the Datapath (slave).
// With CTRL_MEM_WAIT_EN defined, the bundle also carries the memory handshake input MemReady.
interface ctrl_sequencer_if #(parameter int NREG = 16);
  logic [31:0]     IR;
  logic            Start;
  logic            Stop;
`ifdef CTRL_MEM_WAIT_EN
  logic            MemReady;
`endif
  logic            Run;
  logic            PCout, Zhiout, Zlowout, MDRout;
  logic            MARin, PCin, MDRin, IRin, Yin, Zin;
  logic            IncPC, Read;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic            ADD, SUB, SHL, SHR, ROL, ROR, AND, OR;

  modport master (
    input  IR, Start, Stop,
`ifdef CTRL_MEM_WAIT_EN
    input  MemReady,
`endif
    output Run, PCout, Zhiout, Zlowout, MDRout,
    output MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read,
    output Rout, Rin, ADD, SUB, SHL, SHR, ROL, ROR, AND, OR
  );

  modport slave (
    output IR, Start, Stop,
`ifdef CTRL_MEM_WAIT_EN
    output MemReady,
`endif
    input  Run, PCout, Zhiout, Zlowout, MDRout,
    input  MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read,
    input  Rout, Rin, ADD, SUB, SHL, SHR, ROL, ROR, AND, OR
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute control unit for the Datapath (T0-T5 sequence).
// Optional macro CTRL_MEM_WAIT_EN stretches T1 until MemReady is high.
module ctrl_sequencer #(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input logic              Clock,
  input logic              Clear,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    RESET_ST, T0, T1, T2, T3, T4, T5, HALTED
  } state_t;

  state_t          state, next_state;
  logic            stop_pending;
  logic [OPW-1:0]  op;
  logic [3:0]      ra, rb, rc;
  logic            is_alu, is_halt, mem_ready;
  logic [7:0]      alu_sel;
  logic            unused_ir_bits;

  assign op             = bus.IR[31:31-OPW+1];
  assign ra             = bus.IR[26:23];
  assign rb             = bus.IR[22:19];
  assign rc             = bus.IR[18:15];
  assign is_alu         = (op[OPW-1:3] == '0);
  assign is_halt        = (op == '1);
  assign alu_sel        = 8'b1 << op[2:0];
  assign unused_ir_bits = ^bus.IR[14:0];

`ifdef CTRL_MEM_WAIT_EN
  assign mem_ready = bus.MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= RESET_ST;
    else       state <= next_state;
  end

  // A Stop seen while running is remembered until the machine actually parks in HALTED.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)                                        stop_pending <= 1'b0;
    else if (next_state == HALTED && state != HALTED) stop_pending <= 1'b0;
    else if (bus.Stop && state != HALTED)             stop_pending <= 1'b1;
  end

  always_comb begin
    next_state  = state;
    bus.Run     = (state != RESET_ST);
    bus.PCout   = 1'b0;
    bus.Zhiout  = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MDRout  = 1'b0;
    bus.MARin   = 1'b0;
    bus.PCin    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Read    = 1'b0;
    bus.Rout    = '0;
    bus.Rin     = '0;
    bus.ADD     = 1'b0;
    bus.SUB     = 1'b0;
    bus.SHL     = 1'b0;
    bus.SHR     = 1'b0;
    bus.ROL     = 1'b0;
    bus.ROR     = 1'b0;
    bus.AND     = 1'b0;
    bus.OR      = 1'b0;
    unique case (state)
      RESET_ST: next_state = T0;
      T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zin    = 1'b1;
        next_state = T1;
      end
      // The incremented PC is written back only in the cycle memory completes.
      T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        if (mem_ready) begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
          next_state  = T2;
        end
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        next_state = T3;
      end
      T3: begin
        if (is_alu) begin
          bus.Rout   = NREG'(1) << rb;
          bus.Yin    = 1'b1;
          next_state = T4;
        end else if (is_halt) begin
          next_state = HALTED;
        end else begin
          next_state = stop_pending ? HALTED : T0;
        end
      end
      T4: begin
        bus.Rout   = NREG'(1) << rc;
        bus.ADD    = alu_sel[0];
        bus.SUB    = alu_sel[1];
        bus.SHL    = alu_sel[2];
        bus.SHR    = alu_sel[3];
        bus.ROL    = alu_sel[4];
        bus.ROR    = alu_sel[5];
        bus.AND    = alu_sel[6];
        bus.OR     = alu_sel[7];
        bus.Zin    = 1'b1;
        next_state = T5;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        bus.Rin     = NREG'(1) << ra;
        next_state  = stop_pending ? HALTED : T0;
      end
      HALTED: begin
        if (bus.Start) next_state = T0;
      end
      default: next_state = RESET_ST;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer: fetch/execute strobes, HALT, Stop/Start, async Clear.
module tb_ctrl_sequencer;

   // Strobe vector bit positions: {PCout,Zhiout,Zlowout,MDRout,MARin,PCin,MDRin,IRin,Yin,Zin,IncPC,Read,ADD,SUB,SHL,SHR,ROL,ROR,AND,OR}
   localparam logic [19:0] B_PCOUT = 20'h80000, B_ZLOW = 20'h20000, B_MDROUT = 20'h10000;
   localparam logic [19:0] B_MARIN = 20'h08000, B_PCIN = 20'h04000, B_MDRIN = 20'h02000;
   localparam logic [19:0] B_IRIN = 20'h01000, B_YIN = 20'h00800, B_ZIN = 20'h00400;
   localparam logic [19:0] B_INCPC = 20'h00200, B_READ = 20'h00100;
   localparam logic [19:0] B_ADD = 20'h00080, B_SHR = 20'h00010;
   localparam logic [19:0] P_NONE = 20'h0;
   localparam logic [19:0] P_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
   localparam logic [19:0] P_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
   localparam logic [19:0] P_T2 = B_MDROUT | B_IRIN;

   localparam logic [31:0] IR_SHR  = 32'h1A920000;
   localparam logic [31:0] IR_ADD  = 32'h00920000;
   localparam logic [31:0] IR_HALT = 32'hF8000000;
   localparam logic [31:0] IR_NOP  = 32'h40000000;

   logic clock;
   logic clear;
   int   compared;
   int   mismatched;

   ctrl_sequencer_if #(.NREG(16)) bus ();

   ctrl_sequencer dut (
      .Clock (clock),
      .Clear (clear),
      .bus   (bus)
   );

   // Free-running clock with rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the directed sequence ever stalls.
   initial begin
      #20000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one rising edge and settle 1 time unit past it.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   // Compare Run, the scalar strobe vector and the two one-hot register buses.
   task automatic checkOutput(input string tag, input logic expRun, input logic [19:0] expBits,
                              input logic [15:0] expRout, input logic [15:0] expRin);
      logic [19:0] obsBits;
      obsBits = {bus.PCout, bus.Zhiout, bus.Zlowout, bus.MDRout, bus.MARin, bus.PCin, bus.MDRin,
                 bus.IRin, bus.Yin, bus.Zin, bus.IncPC, bus.Read, bus.ADD, bus.SUB, bus.SHL,
                 bus.SHR, bus.ROL, bus.ROR, bus.AND, bus.OR};
      compared++;
      assert (bus.Run === expRun) else begin
         mismatched++;
         $error("[TB] FAIL %s.Run observed %b expected %b", tag, bus.Run, expRun);
      end
      compared++;
      assert (obsBits === expBits) else begin
         mismatched++;
         $error("[TB] FAIL %s.strobes observed %h expected %h", tag, obsBits, expBits);
      end
      compared++;
      assert (bus.Rout === expRout) else begin
         mismatched++;
         $error("[TB] FAIL %s.Rout observed %h expected %h", tag, bus.Rout, expRout);
      end
      compared++;
      assert (bus.Rin === expRin) else begin
         mismatched++;
         $error("[TB] FAIL %s.Rin observed %h expected %h", tag, bus.Rin, expRin);
      end
   endtask

   // Linear directed sequence.
   initial begin
      compared   = 0;
      mismatched = 0;
      clear      = 1'b1;
      bus.IR     = 32'h0;
      bus.Start  = 1'b0;
      bus.Stop   = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
      bus.MemReady = 1'b1;
`endif
      #1;
      checkOutput("reset", 1'b0, P_NONE, 16'h0, 16'h0);
      applyStimulus();
      checkOutput("reset_held", 1'b0, P_NONE, 16'h0, 16'h0);
      clear = 1'b0;

      $display("[TB] SHR R5,R2,R4");
      applyStimulus(); checkOutput("shr_t0", 1'b1, P_T0, 16'h0, 16'h0);
      applyStimulus(); checkOutput("shr_t1", 1'b1, P_T1, 16'h0, 16'h0);
      bus.IR = IR_SHR;
      applyStimulus(); checkOutput("shr_t2", 1'b1, P_T2, 16'h0, 16'h0);
      applyStimulus(); checkOutput("shr_t3", 1'b1, B_YIN, 16'h0004, 16'h0);
      applyStimulus(); checkOutput("shr_t4", 1'b1, B_SHR | B_ZIN, 16'h0010, 16'h0);
      applyStimulus(); checkOutput("shr_t5", 1'b1, B_ZLOW, 16'h0, 16'h0020);

      $display("[TB] ADD R1,R2,R4 back-to-back with Stop during T1");
      applyStimulus(); checkOutput("add_t0", 1'b1, P_T0, 16'h0, 16'h0);
      bus.IR = IR_ADD;
      applyStimulus(); checkOutput("add_t1", 1'b1, P_T1, 16'h0, 16'h0);
      bus.Stop = 1'b1;
      applyStimulus(); checkOutput("add_t2", 1'b1, P_T2, 16'h0, 16'h0);
      bus.Stop = 1'b0;
      applyStimulus(); checkOutput("add_t3", 1'b1, B_YIN, 16'h0004, 16'h0);
      applyStimulus(); checkOutput("add_t4", 1'b1, B_ADD | B_ZIN, 16'h0010, 16'h0);
      applyStimulus(); checkOutput("add_t5", 1'b1, B_ZLOW, 16'h0, 16'h0002);
      applyStimulus(); checkOutput("stop_halted", 1'b1, P_NONE, 16'h0, 16'h0);
      applyStimulus(); checkOutput("stop_halted_hold", 1'b1, P_NONE, 16'h0, 16'h0);

      $display("[TB] Start and Stop together in HALTED, then NOP");
      bus.Start = 1'b1;
      bus.Stop  = 1'b1;
      bus.IR    = IR_NOP;
      applyStimulus(); checkOutput("startstop_t0", 1'b1, P_T0, 16'h0, 16'h0);
      bus.Start = 1'b0;
      bus.Stop  = 1'b0;
      applyStimulus(); checkOutput("nop_t1", 1'b1, P_T1, 16'h0, 16'h0);
      applyStimulus(); checkOutput("nop_t2", 1'b1, P_T2, 16'h0, 16'h0);
      applyStimulus(); checkOutput("nop_t3", 1'b1, P_NONE, 16'h0, 16'h0);
      applyStimulus(); checkOutput("nop_next_t0", 1'b1, P_T0, 16'h0, 16'h0);

      $display("[TB] HALT instruction and Start restart");
      bus.IR = IR_HALT;
      applyStimulus(); checkOutput("halt_t1", 1'b1, P_T1, 16'h0, 16'h0);
      applyStimulus(); checkOutput("halt_t2", 1'b1, P_T2, 16'h0, 16'h0);
      applyStimulus(); checkOutput("halt_t3", 1'b1, P_NONE, 16'h0, 16'h0);
      applyStimulus(); checkOutput("halt_halted", 1'b1, P_NONE, 16'h0, 16'h0);
      applyStimulus(); checkOutput("halt_halted_hold", 1'b1, P_NONE, 16'h0, 16'h0);
      bus.Start = 1'b1;
      applyStimulus(); checkOutput("restart_t0", 1'b1, P_T0, 16'h0, 16'h0);
      bus.Start = 1'b0;

      $display("[TB] Clear asserted in the middle of T4");
      bus.IR = IR_ADD;
      applyStimulus(); checkOutput("clr_t1", 1'b1, P_T1, 16'h0, 16'h0);
      applyStimulus(); checkOutput("clr_t2", 1'b1, P_T2, 16'h0, 16'h0);
      applyStimulus(); checkOutput("clr_t3", 1'b1, B_YIN, 16'h0004, 16'h0);
      applyStimulus(); checkOutput("clr_t4", 1'b1, B_ADD | B_ZIN, 16'h0010, 16'h0);
      #2;
      clear = 1'b1;
      #1;
      checkOutput("clr_async", 1'b0, P_NONE, 16'h0, 16'h0);
      #1;
      clear = 1'b0;
      applyStimulus(); checkOutput("clr_restart_t0", 1'b1, P_T0, 16'h0, 16'h0);

`ifdef CTRL_MEM_WAIT_EN
      $display("[TB] T1 stretched by three MemReady wait cycles");
      bus.MemReady = 1'b0;
      applyStimulus(); checkOutput("wait_t1_a", 1'b1, B_READ | B_MDRIN, 16'h0, 16'h0);
      applyStimulus(); checkOutput("wait_t1_b", 1'b1, B_READ | B_MDRIN, 16'h0, 16'h0);
      applyStimulus(); checkOutput("wait_t1_c", 1'b1, B_READ | B_MDRIN, 16'h0, 16'h0);
      bus.MemReady = 1'b1;
      #1;
      checkOutput("wait_t1_last", 1'b1, P_T1, 16'h0, 16'h0);
      applyStimulus(); checkOutput("wait_t2", 1'b1, P_T2, 16'h0, 16'h0);
`else
      applyStimulus(); checkOutput("final_t1", 1'b1, P_T1, 16'h0, 16'h0);
      applyStimulus(); checkOutput("final_t2", 1'b1, P_T2, 16'h0, 16'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
